// File: rtl/triangle_cull_pipeline_pkg.sv
// Shared types for the triangle cull pipeline: cull modes, packed-vertex field
// positions and the facing/cull decision used in the output stage.
package triangle_cull_pipeline_pkg;

    typedef enum logic [1:0] {
        CULL_NONE  = 2'b00,
        CULL_BACK  = 2'b01,
        CULL_FRONT = 2'b10,
        CULL_ALL   = 2'b11
    } cull_mode_e;

    // Component index inside a packed {x,y,z,w} vertex, x in the MSBs.
    localparam int VTX_X_IDX = 3;
    localparam int VTX_Y_IDX = 2;

    // Zero-area triangles are back-facing under either winding convention.
    function automatic logic cull_decision(input cull_mode_e mode, input logic front_ccw,
                                           input logic neg, input logic zero);
        logic back;
        back = front_ccw ? !neg : (neg || zero);
        case (mode)
            CULL_NONE:  return 1'b0;
            CULL_BACK:  return back;
            CULL_FRONT: return !back || zero;
            CULL_ALL:   return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/triangle_cull_pipeline_cross2d_pipe.sv
// Three-stage full-precision 2D winding cross product (S1 deltas, S2 products,
// S3 difference) with a valid bit and an opaque sideband word per entry.
module cross2d_pipe #(
    parameter int COORD_W = 32,
    parameter int SB_W    = 1
) (
    input  logic                      i_clk,
    input  logic                      i_reset_n,
    input  logic                      i_en,
    input  logic                      i_valid,
    input  logic signed [COORD_W-1:0] i_v1_x,
    input  logic signed [COORD_W-1:0] i_v1_y,
    input  logic signed [COORD_W-1:0] i_v2_x,
    input  logic signed [COORD_W-1:0] i_v2_y,
    input  logic signed [COORD_W-1:0] i_v3_x,
    input  logic signed [COORD_W-1:0] i_v3_y,
    input  logic [SB_W-1:0]           i_sb,
    output logic                      o_valid,
    output logic                      o_neg,
    output logic                      o_zero,
    output logic [SB_W-1:0]           o_sb
);

    localparam int DW = COORD_W + 1;
    localparam int PW = 2 * COORD_W + 2;
    localparam int CW = 2 * COORD_W + 3;

    logic                 s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d, s3_valid_q, s3_valid_d;
    logic signed [DW-1:0] d1x_q, d1x_d, d1y_q, d1y_d, d2x_q, d2x_d, d2y_q, d2y_d;
    logic signed [PW-1:0] p0_q, p0_d, p1_q, p1_d;
    logic signed [CW-1:0] cross_q, cross_d;
    logic [SB_W-1:0]      sb1_q, sb1_d, sb2_q, sb2_d, sb3_q, sb3_d;

    always_comb begin
        // NOTE: every _d defaults to its held value first, so no path leaves one unassigned (no latch).
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        s3_valid_d = s3_valid_q;
        d1x_d      = d1x_q;
        d1y_d      = d1y_q;
        d2x_d      = d2x_q;
        d2y_d      = d2y_q;
        p0_d       = p0_q;
        p1_d       = p1_q;
        cross_d    = cross_q;
        sb1_d      = sb1_q;
        sb2_d      = sb2_q;
        sb3_d      = sb3_q;
        if (i_en) begin
            s1_valid_d = i_valid;
            d1x_d      = DW'(i_v1_x) - DW'(i_v2_x);
            d1y_d      = DW'(i_v1_y) - DW'(i_v2_y);
            d2x_d      = DW'(i_v3_x) - DW'(i_v1_x);
            d2y_d      = DW'(i_v3_y) - DW'(i_v1_y);
            sb1_d      = i_sb;
            s2_valid_d = s1_valid_q;
            p0_d       = PW'(d1x_q) * PW'(d2y_q);
            p1_d       = PW'(d1y_q) * PW'(d2x_q);
            sb2_d      = sb1_q;
            s3_valid_d = s2_valid_q;
            cross_d    = CW'(p0_q) - CW'(p1_q);
            sb3_d      = sb2_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s3_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s3_valid_q <= s3_valid_d;
        end
    end

    // NOTE: datapath registers carry no reset; the valid bits alone qualify them.
    always_ff @(posedge i_clk) begin
        d1x_q   <= d1x_d;
        d1y_q   <= d1y_d;
        d2x_q   <= d2x_d;
        d2y_q   <= d2y_d;
        p0_q    <= p0_d;
        p1_q    <= p1_d;
        cross_q <= cross_d;
        sb1_q   <= sb1_d;
        sb2_q   <= sb2_d;
        sb3_q   <= sb3_d;
    end

    assign o_valid = s3_valid_q;
    assign o_neg   = cross_q[CW-1];
    assign o_zero  = (cross_q == '0);
    assign o_sb    = sb3_q;

endmodule

// File: rtl/triangle_cull_pipeline.sv
// Streaming back/front-face culler: valid/ready handshake around cross2d_pipe.
// Define TRIANGLE_CULL_STATS_EN to add saturating culled/passed counters.
module triangle_cull_pipeline
    import triangle_cull_pipeline_pkg::*;
#(
    parameter int COORD_W = 32,
    parameter int TAG_W   = 8
`ifdef TRIANGLE_CULL_STATS_EN
    ,
    parameter int STAT_W  = 32
`endif
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [4*COORD_W-1:0] i_v1,
    input  logic [4*COORD_W-1:0] i_v2,
    input  logic [4*COORD_W-1:0] i_v3,
    input  logic [TAG_W-1:0]     i_tag,
    input  logic [1:0]           i_cull_mode,
    input  logic                 i_front_ccw,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [4*COORD_W-1:0] o_v1,
    output logic [4*COORD_W-1:0] o_v2,
    output logic [4*COORD_W-1:0] o_v3,
    output logic [TAG_W-1:0]     o_tag
`ifdef TRIANGLE_CULL_STATS_EN
    ,
    output logic [STAT_W-1:0]    o_culled_count,
    output logic [STAT_W-1:0]    o_passed_count
`endif
);

    localparam int VW = 4 * COORD_W;

    // Everything that rides alongside the arithmetic, including the captured mode.
    typedef struct packed {
        logic [VW-1:0]    v1;
        logic [VW-1:0]    v2;
        logic [VW-1:0]    v3;
        logic [TAG_W-1:0] tag;
        cull_mode_e       mode;
        logic             front_ccw;
    } tri_sb_t;

    localparam int SB_W = $bits(tri_sb_t);

    tri_sb_t   in_sb, s3_sb;
    logic      s3_valid, s3_neg, s3_zero, s3_culled, stall;

    assign in_sb = '{v1: i_v1, v2: i_v2, v3: i_v3, tag: i_tag,
                     mode: cull_mode_e'(i_cull_mode), front_ccw: i_front_ccw};

    cross2d_pipe #(
        .COORD_W (COORD_W),
        .SB_W    (SB_W)
    ) u_cross2d_pipe (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_en      (!stall),
        .i_valid   (i_valid),
        .i_v1_x    (i_v1[VTX_X_IDX*COORD_W +: COORD_W]),
        .i_v1_y    (i_v1[VTX_Y_IDX*COORD_W +: COORD_W]),
        .i_v2_x    (i_v2[VTX_X_IDX*COORD_W +: COORD_W]),
        .i_v2_y    (i_v2[VTX_Y_IDX*COORD_W +: COORD_W]),
        .i_v3_x    (i_v3[VTX_X_IDX*COORD_W +: COORD_W]),
        .i_v3_y    (i_v3[VTX_Y_IDX*COORD_W +: COORD_W]),
        .i_sb      (in_sb),
        .o_valid   (s3_valid),
        .o_neg     (s3_neg),
        .o_zero    (s3_zero),
        .o_sb      (s3_sb)
    );

    // A culled S3 entry never raises o_valid, so it cannot stall and is overwritten next cycle.
    assign s3_culled = cull_decision(s3_sb.mode, s3_sb.front_ccw, s3_neg, s3_zero);
    assign o_valid   = s3_valid && !s3_culled;
    assign stall     = o_valid && !i_ready;
    assign o_ready   = !stall;
    assign o_v1      = s3_sb.v1;
    assign o_v2      = s3_sb.v2;
    assign o_v3      = s3_sb.v3;
    assign o_tag     = s3_sb.tag;

`ifdef TRIANGLE_CULL_STATS_EN
    logic [STAT_W-1:0] culled_cnt_q, culled_cnt_d, passed_cnt_q, passed_cnt_d;

    always_comb begin
        culled_cnt_d = culled_cnt_q;
        passed_cnt_d = passed_cnt_q;
        if (s3_valid && s3_culled && (culled_cnt_q != '1))
            culled_cnt_d = culled_cnt_q + STAT_W'(1);
        if (o_valid && i_ready && (passed_cnt_q != '1))
            passed_cnt_d = passed_cnt_q + STAT_W'(1);
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            culled_cnt_q <= '0;
            passed_cnt_q <= '0;
        end else begin
            culled_cnt_q <= culled_cnt_d;
            passed_cnt_q <= passed_cnt_d;
        end
    end

    assign o_culled_count = culled_cnt_q;
    assign o_passed_count = passed_cnt_q;
`endif

endmodule

// File: tb/tb_triangle_cull_pipeline.sv
// Directed self-checking bench for triangle_cull_pipeline (default parameters).
module tb_triangle_cull_pipeline;
    import triangle_cull_pipeline_pkg::*;

    logic         i_clk = 1'b0;
    logic         i_reset_n;
    logic         i_valid;
    logic         o_ready;
    logic [127:0] i_v1, i_v2, i_v3;
    logic [7:0]   i_tag;
    logic [1:0]   i_cull_mode;
    logic         i_front_ccw;
    logic         o_valid;
    logic         i_ready;
    logic [127:0] o_v1, o_v2, o_v3;
    logic [7:0]   o_tag;
`ifdef TRIANGLE_CULL_STATS_EN
    logic [31:0]  o_culled_count, o_passed_count;
`endif

    always #5 i_clk = ~i_clk;

    triangle_cull_pipeline dut (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_v1        (i_v1),
        .i_v2        (i_v2),
        .i_v3        (i_v3),
        .i_tag       (i_tag),
        .i_cull_mode (i_cull_mode),
        .i_front_ccw (i_front_ccw),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_v1        (o_v1),
        .o_v2        (o_v2),
        .o_v3        (o_v3),
        .o_tag       (o_tag)
`ifdef TRIANGLE_CULL_STATS_EN
        ,
        .o_culled_count (o_culled_count),
        .o_passed_count (o_passed_count)
`endif
    );

    int checks   = 0;
    int failures = 0;
    int exp_culled = 0;
    int exp_passed = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    logic [7:0]   out_tag_q[$];
    int           out_cyc_q[$];
    logic [127:0] out_v1_q[$];
    logic [127:0] out_v3_q[$];
    int           tx_cyc[256];

    always @(negedge i_clk) begin
        if (o_valid && i_ready) begin
            out_tag_q.push_back(o_tag);
            out_cyc_q.push_back(cyc);
            out_v1_q.push_back(o_v1);
            out_v3_q.push_back(o_v3);
        end
    end

    localparam int MAXC = 32'sh7fff_ffff;
    localparam int MINC = 32'sh8000_0000;

    function automatic logic [127:0] vtx(input int x, input int y);
        return {x, y, x ^ 32'h0000_5a5a, 32'h0001_0000};
    endfunction

    task automatic clear_out();
        out_tag_q.delete();
        out_cyc_q.delete();
        out_v1_q.delete();
        out_v3_q.delete();
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the transfer edge.
    task automatic send(input logic [127:0] v1, input logic [127:0] v2, input logic [127:0] v3,
                        input logic [7:0] tag, input cull_mode_e mode, input logic ccw);
        int n;
        i_v1 = v1; i_v2 = v2; i_v3 = v3;
        i_tag = tag; i_cull_mode = mode; i_front_ccw = ccw;
        i_valid = 1'b1;
        n = 0;
        @(negedge i_clk);
        while (!o_ready && n < 50) begin
            n++;
            @(negedge i_clk);
        end
        if (n >= 50) check("send_ready_timeout", o_ready, 1'b1);
        tx_cyc[tag] = cyc;
        @(posedge i_clk);
        #1;
    endtask

    task automatic check_counters(input string name);
`ifdef TRIANGLE_CULL_STATS_EN
        check({name, "_culled_count"}, o_culled_count, exp_culled);
        check({name, "_passed_count"}, o_passed_count, exp_passed);
`else
        if (name.len() < 0) $display("%s", name);
`endif
    endtask

    task automatic run_one(input string name, input logic [127:0] v1, input logic [127:0] v2,
                           input logic [127:0] v3, input cull_mode_e mode, input logic ccw,
                           input logic [7:0] tag, input bit exp_pass);
        clear_out();
        send(v1, v2, v3, tag, mode, ccw);
        i_valid = 1'b0;
        wait_cycles(6);
        check({name, "_count"}, out_tag_q.size(), exp_pass ? 1 : 0);
        if (out_tag_q.size() == 1) begin
            check({name, "_tag"}, out_tag_q[0], tag);
            check({name, "_v1"}, out_v1_q[0], v1);
            check({name, "_v3"}, out_v3_q[0], v3);
            check({name, "_latency"}, out_cyc_q[0] - tx_cyc[tag], 3);
        end
        if (exp_pass) exp_passed++;
        else exp_culled++;
        check_counters(name);
    endtask

    logic [127:0] a1, a2, a3, b1, b2, b3, c1, c2, c3;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        // A: cross = -100 (front for ccw=1); B: cross = +100; C: collinear, cross = 0.
        a1 = vtx(0, 0); a2 = vtx(10, 0); a3 = vtx(0, 10);
        b1 = vtx(0, 0); b2 = vtx(0, 10); b3 = vtx(10, 0);
        c1 = vtx(0, 0); c2 = vtx(5, 5);  c3 = vtx(10, 10);

        i_reset_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
        i_v1 = '0; i_v2 = '0; i_v3 = '0; i_tag = '0; i_cull_mode = 2'b00; i_front_ccw = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        i_reset_n = 1'b1;
        wait_cycles(1);
        check("reset_o_valid", o_valid, 1'b0);
        check("reset_o_ready", o_ready, 1'b1);
        check_counters("reset");

        run_one("a_back_ccw1",  a1, a2, a3, CULL_BACK,  1'b1, 8'hA1, 1'b1);
        run_one("b_back_ccw1",  b1, b2, b3, CULL_BACK,  1'b1, 8'hA2, 1'b0);
        run_one("b_front_ccw1", b1, b2, b3, CULL_FRONT, 1'b1, 8'hA3, 1'b1);
        run_one("a_front_ccw1", a1, a2, a3, CULL_FRONT, 1'b1, 8'hA4, 1'b0);
        run_one("a_back_ccw0",  a1, a2, a3, CULL_BACK,  1'b0, 8'hA5, 1'b0);
        run_one("b_back_ccw0",  b1, b2, b3, CULL_BACK,  1'b0, 8'hA6, 1'b1);
        run_one("a_front_ccw0", a1, a2, a3, CULL_FRONT, 1'b0, 8'hA7, 1'b1);
        run_one("b_front_ccw0", b1, b2, b3, CULL_FRONT, 1'b0, 8'hA8, 1'b0);
        run_one("c_back_ccw1",  c1, c2, c3, CULL_BACK,  1'b1, 8'hB1, 1'b0);
        run_one("c_front_ccw1", c1, c2, c3, CULL_FRONT, 1'b1, 8'hB2, 1'b0);
        run_one("c_none",       c1, c2, c3, CULL_NONE,  1'b1, 8'hB3, 1'b1);
        run_one("c_back_ccw0",  c1, c2, c3, CULL_BACK,  1'b0, 8'hB4, 1'b0);
        run_one("c_front_ccw0", c1, c2, c3, CULL_FRONT, 1'b0, 8'hB5, 1'b0);
        run_one("a_none",       a1, a2, a3, CULL_NONE,  1'b1, 8'hB6, 1'b1);
        run_one("a_all",        a1, a2, a3, CULL_ALL,   1'b1, 8'hB7, 1'b0);

        // Extremes: |deltas| reach 2^32-1, products near 2^64.
        run_one("ext_front", vtx(MINC, MINC), vtx(MAXC, MINC), vtx(MINC, MAXC),
                CULL_BACK, 1'b1, 8'hC1, 1'b1);
        run_one("ext_back",  vtx(MINC, MINC), vtx(MINC, MAXC), vtx(MAXC, MINC),
                CULL_BACK, 1'b1, 8'hC2, 1'b0);
        run_one("ext2_front_mode", vtx(MAXC, MAXC), vtx(MINC, MAXC), vtx(MAXC, MINC),
                CULL_FRONT, 1'b1, 8'hC3, 1'b0);
        run_one("ext2_back_mode",  vtx(MAXC, MAXC), vtx(MINC, MAXC), vtx(MAXC, MINC),
                CULL_BACK, 1'b1, 8'hC4, 1'b1);

        // Back-to-back alternating front/back stream, mode BACK.
        clear_out();
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) send(a1, a2, a3, 8'(i), CULL_BACK, 1'b1);
            else            send(b1, b2, b3, 8'(i), CULL_BACK, 1'b1);
        end
        i_valid = 1'b0;
        wait_cycles(6);
        check("stream_count", out_tag_q.size(), 4);
        for (int k = 0; k < 4 && k < out_tag_q.size(); k++) begin
            check($sformatf("stream_tag%0d", k), out_tag_q[k], 8'(2 * k));
            check($sformatf("stream_latency%0d", k), out_cyc_q[k] - tx_cyc[2 * k], 3);
        end
        check("stream_tx_rate", tx_cyc[7] - tx_cyc[0], 7);
        exp_passed += 4;
        exp_culled += 4;
        check_counters("stream");

        // Downstream stall of 5 cycles mid-stream.
        clear_out();
        fork
            begin
                for (int i = 0; i < 8; i++) send(a1, a2, a3, 8'(16 + i), CULL_BACK, 1'b1);
                i_valid = 1'b0;
            end
            begin
                logic [7:0]   held_tag;
                logic [127:0] held_v1;
                int n;
                n = 0;
                while (out_tag_q.size() < 2 && n < 50) begin
                    n++;
                    @(negedge i_clk);
                end
                if (n >= 50) check("stall_wait_timeout", out_tag_q.size(), 2);
                @(posedge i_clk);
                #1;
                i_ready = 1'b0;
                @(negedge i_clk);
                held_tag = o_tag;
                held_v1  = o_v1;
                check("stall_o_ready_0", o_ready, 1'b0);
                check("stall_o_valid_0", o_valid, 1'b1);
                for (int c = 1; c < 5; c++) begin
                    @(negedge i_clk);
                    check($sformatf("stall_o_ready_%0d", c), o_ready, 1'b0);
                    check($sformatf("stall_o_valid_%0d", c), o_valid, 1'b1);
                    check($sformatf("stall_tag_stable_%0d", c), o_tag, held_tag);
                    check($sformatf("stall_v1_stable_%0d", c), o_v1, held_v1);
                end
                @(posedge i_clk);
                #1;
                i_ready = 1'b1;
            end
        join
        wait_cycles(8);
        check("stall_count", out_tag_q.size(), 8);
        for (int k = 0; k < 8 && k < out_tag_q.size(); k++)
            check($sformatf("stall_order%0d", k), out_tag_q[k], 8'(16 + k));
        exp_passed += 8;
        check_counters("stall");

        // Reset with three triangles in flight (head stalled in S3).
        clear_out();
        i_ready = 1'b0;
        send(a1, a2, a3, 8'h30, CULL_BACK, 1'b1);
        send(a1, a2, a3, 8'h31, CULL_BACK, 1'b1);
        send(a1, a2, a3, 8'h32, CULL_BACK, 1'b1);
        i_valid = 1'b0;
        check("inflight_o_valid", o_valid, 1'b1);
        i_reset_n = 1'b0;
        wait_cycles(2);
        check("midreset_o_valid", o_valid, 1'b0);
        i_reset_n = 1'b1;
        i_ready = 1'b1;
        wait_cycles(1);
        check("postreset_o_ready", o_ready, 1'b1);
        wait_cycles(6);
        check("postreset_outputs", out_tag_q.size(), 0);
        check("postreset_o_valid", o_valid, 1'b0);
        exp_passed = 0;
        exp_culled = 0;
        check_counters("postreset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
